raid_parity_writeback: RTL and testbench

//  Downstream of the read-path data write-back stage.

---
 rtl/raid_parity_writeback.sv | 184 ++++++++++++++++++
 tb/tb_raid_parity_writeback.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/raid_parity_writeback.sv
`default_nettype none
// ============================================================================
// Module   : raid_parity_writeback
// Purpose  : Recomputes the parity strip of a stripe after one or both data
//            strips were rewritten (parity = new_D0 ^ new_D1) and writes it to
//            the stripe's parity disk (addr % 3) over a req/ack handshake with
//            a bounded wait for the acknowledge.
// Ports    : clk, reset (async assert, active-high)
//            in_valid/addr/write_d0/write_d1/corr_d*/old_d* : update request
//            par_wr_ack                                      : memory accept
//            par_wr_req/par_wr_en/par_wr_data/par_wr_addr    : parity write
//            busy, done, timeout_err, overrun                : status
// Revision : 1.0 - initial release
// ============================================================================
module raid_parity_writeback #(
  parameter int DATA_W      = 12,
  parameter int ADDR_W      = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic              write_d0,
  input  logic              write_d1,
  input  logic [DATA_W-1:0] corr_d0,
  input  logic [DATA_W-1:0] corr_d1,
  input  logic [DATA_W-1:0] old_d0,
  input  logic [DATA_W-1:0] old_d1,
  input  logic              par_wr_ack,
  output logic              par_wr_req,
  output logic [2:0]        par_wr_en,
  output logic [DATA_W-1:0] par_wr_data,
  output logic [ADDR_W-1:0] par_wr_addr,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_REQ  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wd0_q, wd0_d, wd1_q, wd1_d;
  logic [DATA_W-1:0] c0_q, c0_d, c1_q, c1_d, o0_q, o0_d, o1_q, o1_d;
  logic              req_q, req_d;
  logic [2:0]        en_q, en_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d, tmo_q, tmo_d, ovr_q, ovr_d;

  logic [ADDR_W-1:0] w_mod;
  logic [DATA_W-1:0] w_sel0, w_sel1;

  // Full-width modulo so every address maps to its true parity disk.
  assign w_mod  = addr_q % ADDR_W'(3);
  assign w_sel0 = wd0_q ? c0_q : o0_q;
  assign w_sel1 = wd1_q ? c1_q : o1_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wd0_d   = wd0_q;
    wd1_d   = wd1_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    o0_d    = o0_q;
    o1_d    = o1_q;
    req_d   = req_q;
    en_d    = en_q;
    data_d  = data_q;
    paddr_d = paddr_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    tmo_d   = tmo_q;
    // A request arriving while an operation is in flight is dropped and flagged.
    ovr_d   = in_valid && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (in_valid && (write_d0 || write_d1)) begin
          addr_d  = addr;
          wd0_d   = write_d0;
          wd1_d   = write_d1;
          c0_d    = corr_d0;
          c1_d    = corr_d1;
          o0_d    = old_d0;
          o1_d    = old_d1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        // XOR of two valid codewords is a valid codeword: no re-encode needed.
        data_d  = w_sel0 ^ w_sel1;
        paddr_d = addr_q;
        if (w_mod == ADDR_W'(0))      en_d = 3'b001;
        else if (w_mod == ADDR_W'(1)) en_d = 3'b010;
        else                          en_d = 3'b100;
        req_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_REQ;
      end
      S_REQ: begin
        // Ack takes priority over a simultaneous timeout.
        if (par_wr_ack || (cnt_q == C_CNT_LAST)) begin
          req_d   = 1'b0;
          en_d    = '0;
          data_d  = '0;
          paddr_d = '0;
          done_d  = 1'b1;
          tmo_d   = !par_wr_ack;
          state_d = S_DONE;
        end else if (cnt_q != C_CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wd0_q   <= 1'b0;
      wd1_q   <= 1'b0;
      c0_q    <= '0;
      c1_q    <= '0;
      o0_q    <= '0;
      o1_q    <= '0;
      req_q   <= 1'b0;
      en_q    <= '0;
      data_q  <= '0;
      paddr_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wd0_q   <= wd0_d;
      wd1_q   <= wd1_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      o0_q    <= o0_d;
      o1_q    <= o1_d;
      req_q   <= req_d;
      en_q    <= en_d;
      data_q  <= data_d;
      paddr_q <= paddr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
    end
  end

  assign par_wr_req  = req_q;
  assign par_wr_en   = en_q;
  assign par_wr_data = data_q;
  assign par_wr_addr = paddr_q;
  assign done        = done_q;
  assign timeout_err = tmo_q;
  assign overrun     = ovr_q;
  assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_raid_parity_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_raid_parity_writeback
// Purpose  : Self-checking bench for raid_parity_writeback: directed cases
//            plus randomized stripe updates against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_raid_parity_writeback;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  addr = '0;
  logic        write_d0 = 1'b0, write_d1 = 1'b0;
  logic [11:0] corr_d0 = '0, corr_d1 = '0, old_d0 = '0, old_d1 = '0;
  logic        par_wr_ack = 1'b0;
  logic        par_wr_req;
  logic [2:0]  par_wr_en;
  logic [11:0] par_wr_data;
  logic [7:0]  par_wr_addr;
  logic        busy, done, timeout_err, overrun;

  int n_checks = 0;
  int n_errors = 0;

  raid_parity_writeback #(.DATA_W(12), .ADDR_W(8), .ACK_TIMEOUT(15)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .addr(addr),
    .write_d0(write_d0), .write_d1(write_d1),
    .corr_d0(corr_d0), .corr_d1(corr_d1), .old_d0(old_d0), .old_d1(old_d1),
    .par_wr_ack(par_wr_ack), .par_wr_req(par_wr_req), .par_wr_en(par_wr_en),
    .par_wr_data(par_wr_data), .par_wr_addr(par_wr_addr), .busy(busy),
    .done(done), .timeout_err(timeout_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},  par_wr_req, 0);
    check({tag, "_en"},   par_wr_en, 0);
    check({tag, "_data"}, par_wr_data, 0);
    check({tag, "_addr"}, par_wr_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_tmo"},  timeout_err, 0);
    check({tag, "_ovr"},  overrun, 0);
  endtask

  task automatic scramble_inputs();
    addr    = 8'($urandom);
    write_d0 = 1'($urandom);
    write_d1 = 1'($urandom);
    corr_d0 = 12'($urandom);
    corr_d1 = 12'($urandom);
    old_d0  = 12'($urandom);
    old_d1  = 12'($urandom);
  endtask

  // One stripe update. ack_dly: REQ cycle index (0-based) in which ack is
  // driven; >= 15 means never. ov_at: REQ cycle index in which a stray
  // in_valid is injected (-1 for none).
  task automatic do_op(input logic [7:0] a, input logic w0, input logic w1,
                       input logic [11:0] c0, input logic [11:0] c1,
                       input logic [11:0] o0, input logic [11:0] o1,
                       input int ack_dly, input int ov_at);
    logic [11:0] exp_data;
    logic [2:0]  exp_en;
    logic        exp_to;
    int          exp_cycles;
    int          cyc;
    logic        ov_pend;
    int          n_done;

    exp_data   = (w0 ? c0 : o0) ^ (w1 ? c1 : o1);
    exp_en     = 3'b001 << (a % 3);
    exp_to     = (ack_dly >= 15);
    exp_cycles = exp_to ? 15 : ack_dly + 1;

    @(posedge clk); #1;
    in_valid = 1'b1; addr = a; write_d0 = w0; write_d1 = w1;
    corr_d0 = c0; corr_d1 = c1; old_d0 = o0; old_d1 = o1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_inputs();
    check("calc_busy", busy, 1);
    check("calc_req", par_wr_req, 0);
    @(posedge clk); #1;

    cyc = 0; ov_pend = 1'b0; n_done = 0;
    while (par_wr_req === 1'b1 && cyc < 40) begin
      check("req_ovr",  overrun, ov_pend);
      check("req_en",   par_wr_en, exp_en);
      check("req_data", par_wr_data, exp_data);
      check("req_addr", par_wr_addr, a);
      check("req_done", done, 0);
      par_wr_ack = (cyc == ack_dly);
      in_valid   = (cyc == ov_at);
      if (in_valid) begin
        write_d0 = 1'b1;
        addr = a + 8'd1;
        corr_d0 = ~exp_data;
      end
      ov_pend = in_valid;
      cyc++;
      @(posedge clk); #1;
      par_wr_ack = 1'b0;
      in_valid   = 1'b0;
    end
    check("req_cycles", cyc, exp_cycles);
    check("fin_done", done, 1);
    check("fin_tmo",  timeout_err, exp_to);
    check("fin_req",  par_wr_req, 0);
    check("fin_en",   par_wr_en, 0);
    check("fin_data", par_wr_data, 0);
    check("fin_addr", par_wr_addr, 0);
    check("fin_busy", busy, 1);
    check("fin_ovr",  overrun, ov_pend);
    if (done === 1'b1) n_done++;
    @(posedge clk); #1;
    check("idle_done", done, 0);
    check("idle_tmo",  timeout_err, 0);
    check("idle_busy", busy, 0);
    if (done === 1'b1) n_done++;
    check("done_pulses", n_done, 1);
  endtask

  initial begin
    // Reset state
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    check_all_zero("post_reset");

    // 1: single strip rewrite, ack one cycle after req
    do_op(8'h00, 1, 0, 12'hA5C, 12'h000, 12'h000, 12'h3F0, 1, -1);
    // 2: both strips, immediate ack
    do_op(8'h04, 1, 1, 12'hFFF, 12'h00F, 12'h000, 12'h000, 0, -1);
    // 3: D1 only, parity cancels to zero
    do_op(8'h05, 0, 1, 12'h000, 12'h123, 12'h123, 12'h000, 0, -1);
    // 3b: no write flags -> ignored
    @(posedge clk); #1;
    in_valid = 1'b1; addr = 8'h05; write_d0 = 0; write_d1 = 0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ign_busy", busy, 0);
    check("ign_ovr", overrun, 0);
    @(posedge clk); #1;
    check("ign_req", par_wr_req, 0);
    check("ign_busy2", busy, 0);
    // 4: timeout, then ack in the final allowed cycle
    do_op(8'hFF, 1, 0, 12'h5A5, 12'h000, 12'h000, 12'h0F0, 99, -1);
    do_op(8'hFF, 1, 0, 12'h5A5, 12'h000, 12'h000, 12'h0F0, 14, -1);
    // 5: stray request while in REQ
    do_op(8'h11, 1, 1, 12'h321, 12'h654, 12'h000, 12'h000, 4, 2);
    // 6: reset mid-REQ
    @(posedge clk); #1;
    in_valid = 1'b1; addr = 8'h07; write_d0 = 1; write_d1 = 0;
    corr_d0 = 12'hABC; old_d1 = 12'h111;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_req", par_wr_req, 1);
    reset = 1'b1;
    #1;
    check_all_zero("abort");
    @(posedge clk); #1;
    reset = 1'b0;
    check_all_zero("abort_rel");
    do_op(8'h00, 1, 0, 12'hA5C, 12'h000, 12'h000, 12'h3F0, 1, -1);

    // Randomized updates
    for (int i = 0; i < 30; i++) begin
      int d, ov;
      logic w0, w1;
      w0 = 1'($urandom);
      w1 = 1'($urandom);
      if (!w0 && !w1) w0 = 1'b1;
      case ($urandom_range(0, 5))
        0: d = 0;
        1: d = 1;
        2: d = $urandom_range(2, 6);
        3: d = 13;
        4: d = 14;
        default: d = 15 + $urandom_range(0, 5);
      endcase
      ov = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1;
      if (ov > d) ov = -1;
      do_op(8'($urandom), w0, w1, 12'($urandom), 12'($urandom),
            12'($urandom), 12'($urandom), d, ov);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
